// File: rtl/axi_stride_read_initiator.sv
// Strided AXI read initiator: issues a run of single-ID read bursts at
// base, base+stride, ... and consumes the R beats. It checks R framing per
// burst, folds the returned data into an XOR checksum, and keeps counters
// plus a sticky first-error code.
module axi_stride_read_initiator #(
  parameter int unsigned ADDR_BITS            = 16,
  parameter int unsigned BURST_LEN_WIDTH      = 8,
  parameter int unsigned TID_WIDTH            = 8,
  parameter int unsigned LOG_BLOCK_DATA_BYTES = 0,
  parameter int unsigned LOG_MAX_OUTSTANDING  = 3,
  parameter int unsigned CNT_WIDTH            = 16
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  start,
  input  logic [ADDR_BITS-1:0]                  cfg_base,
  input  logic [ADDR_BITS-1:0]                  cfg_stride,
  input  logic [CNT_WIDTH-1:0]                  cfg_num_req,
  input  logic [BURST_LEN_WIDTH-1:0]            cfg_len,
  input  logic [TID_WIDTH-1:0]                  cfg_id,
  input  logic [LOG_MAX_OUTSTANDING:0]          cfg_max_outstanding,
  input  logic [CNT_WIDTH-1:0]                  cfg_watchdog,
  output logic                                  m_ar_valid,
  input  logic                                  m_ar_ready,
  output logic [ADDR_BITS-1:0]                  m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
  output logic [TID_WIDTH-1:0]                  m_ar_id,
  input  logic                                  m_r_valid,
  output logic                                  m_r_ready,
  input  logic                                  m_r_last,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
  input  logic [TID_WIDTH-1:0]                  m_r_id,
  output logic                                  busy,
  output logic                                  done,
  output logic [CNT_WIDTH-1:0]                  issued_cnt,
  output logic [CNT_WIDTH-1:0]                  beats_cnt,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  data_xor,
  output logic [2:0]                            errorCode
);

  localparam int unsigned DataW = 8 << LOG_BLOCK_DATA_BYTES;
  localparam int unsigned OutW  = LOG_MAX_OUTSTANDING + 1;

  localparam logic [OutW-1:0]            OutOne  = {{(OutW-1){1'b0}}, 1'b1};
  localparam logic [OutW-1:0]            OutCeil = {1'b1, {LOG_MAX_OUTSTANDING{1'b0}}};
  localparam logic [CNT_WIDTH-1:0]       CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_LEN_WIDTH-1:0] LenOne  = {{(BURST_LEN_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [2:0] ErrNone    = 3'd0;
  localparam logic [2:0] ErrId      = 3'd1;
  localparam logic [2:0] ErrEarly   = 3'd2;
  localparam logic [2:0] ErrNoLast  = 3'd3;
  localparam logic [2:0] ErrStray   = 3'd4;
  localparam logic [2:0] ErrTimeout = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                     state_q, state_d;
  logic [CNT_WIDTH-1:0]       num_req_q, num_req_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [TID_WIDTH-1:0]       id_q, id_d;
  logic [OutW-1:0]            limit_q, limit_d;
  logic [CNT_WIDTH-1:0]       wd_limit_q, wd_limit_d;
  logic [ADDR_BITS-1:0]       stride_q, stride_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic [CNT_WIDTH-1:0]       issued_q, issued_d;
  logic [CNT_WIDTH-1:0]       beats_q, beats_d;
  logic [DataW-1:0]           xor_q, xor_d;
  logic [2:0]                 err_q, err_d;
  logic [OutW-1:0]            outst_q, outst_d;
  logic [BURST_LEN_WIDTH-1:0] beat_idx_q, beat_idx_d;
  logic [CNT_WIDTH-1:0]       wd_cnt_q, wd_cnt_d;
  logic                       ar_pend_q, ar_pend_d;
  logic                       done_q, done_d;

  logic       can_issue;
  logic       ar_valid;
  logic       ar_hs;
  logic       r_hs;
  logic       r_last_dec;
  logic       timeout;
  logic [2:0] r_err;

  // Handshake qualifiers; a pending AR stays valid even once issuing has stopped.
  always_comb begin
    can_issue  = (state_q == StRun) && (issued_q < num_req_q) && (outst_q < limit_q) &&
                 (err_q == ErrNone);
    ar_valid   = ar_pend_q | can_issue;
    ar_hs      = ar_valid & m_ar_ready;
    r_hs       = m_r_valid;
    r_last_dec = r_hs & m_r_last & (outst_q != '0);
    timeout    = (state_q != StIdle) && (wd_limit_q != '0) && (wd_cnt_q == wd_limit_q);
  end

  // Classify each R beat; the first matching check wins.
  always_comb begin
    r_err = ErrNone;
    if (r_hs) begin
      if (outst_q == '0) begin
        r_err = ErrStray;
      end else if (m_r_id != id_q) begin
        r_err = ErrId;
      end else if (m_r_last && (beat_idx_q < len_q)) begin
        r_err = ErrEarly;
      end else if ((beat_idx_q == len_q) && !m_r_last) begin
        r_err = ErrNoLast;
      end
    end
  end

  // Next-state for FSM, counters, checksum and error tracking.
  always_comb begin
    state_d    = state_q;
    num_req_d  = num_req_q;
    len_d      = len_q;
    id_d       = id_q;
    limit_d    = limit_q;
    wd_limit_d = wd_limit_q;
    stride_d   = stride_q;
    addr_d     = addr_q;
    issued_d   = issued_q;
    beats_d    = beats_q;
    xor_d      = xor_q;
    err_d      = err_q;
    outst_d    = outst_q;
    beat_idx_d = beat_idx_q;
    wd_cnt_d   = wd_cnt_q;
    ar_pend_d  = ar_valid & ~m_ar_ready;
    done_d     = 1'b0;

    if (ar_hs) begin
      addr_d = addr_q + stride_q;
      if (issued_q != '1) begin
        issued_d = issued_q + CntOne;
      end
    end

    if (r_hs) begin
      if (beats_q != '1) begin
        beats_d = beats_q + CntOne;
      end
      xor_d      = xor_q ^ m_r_data;
      beat_idx_d = m_r_last ? '0 : beat_idx_q + LenOne;
    end

    unique case ({ar_hs, r_last_dec})
      2'b10:   outst_d = outst_q + OutOne;
      2'b01:   outst_d = outst_q - OutOne;
      default: outst_d = outst_q;
    endcase

    if ((err_q == ErrNone) && (r_err != ErrNone)) begin
      err_d = r_err;
    end

    if (ar_hs || r_hs) begin
      wd_cnt_d = '0;
    end else if ((state_q != StIdle) && (outst_q != '0) && (wd_cnt_q != '1)) begin
      wd_cnt_d = wd_cnt_q + CntOne;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_req_d  = cfg_num_req;
          len_d      = cfg_len;
          id_d       = cfg_id;
          wd_limit_d = cfg_watchdog;
          stride_d   = cfg_stride;
          addr_d     = cfg_base;
          // Limit of 0 means 1; anything above the hard ceiling is clipped.
          if (cfg_max_outstanding == '0) begin
            limit_d = OutOne;
          end else if (cfg_max_outstanding > OutCeil) begin
            limit_d = OutCeil;
          end else begin
            limit_d = cfg_max_outstanding;
          end
          issued_d   = '0;
          beats_d    = '0;
          xor_d      = '0;
          err_d      = ErrNone;
          beat_idx_d = '0;
          wd_cnt_d   = '0;
          state_d    = (cfg_num_req == '0) ? StDrain : StRun;
        end
      end
      StRun: begin
        if ((issued_q >= num_req_q) || ((err_q != ErrNone) && !ar_pend_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (outst_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Timeout abandons whatever is in flight.
    if (timeout) begin
      state_d   = StIdle;
      done_d    = 1'b1;
      outst_d   = '0;
      ar_pend_d = 1'b0;
      wd_cnt_d  = '0;
      if (err_q == ErrNone) begin
        err_d = ErrTimeout;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q    <= StIdle;
      num_req_q  <= '0;
      len_q      <= '0;
      id_q       <= '0;
      limit_q    <= OutOne;
      wd_limit_q <= '0;
      stride_q   <= '0;
      addr_q     <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      xor_q      <= '0;
      err_q      <= ErrNone;
      outst_q    <= '0;
      beat_idx_q <= '0;
      wd_cnt_q   <= '0;
      ar_pend_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_req_q  <= num_req_d;
      len_q      <= len_d;
      id_q       <= id_d;
      limit_q    <= limit_d;
      wd_limit_q <= wd_limit_d;
      stride_q   <= stride_d;
      addr_q     <= addr_d;
      issued_q   <= issued_d;
      beats_q    <= beats_d;
      xor_q      <= xor_d;
      err_q      <= err_d;
      outst_q    <= outst_d;
      beat_idx_q <= beat_idx_d;
      wd_cnt_q   <= wd_cnt_d;
      ar_pend_q  <= ar_pend_d;
      done_q     <= done_d;
    end
  end

  // Output mapping.
  always_comb begin
    m_ar_valid = ar_valid;
    m_ar_addr  = addr_q;
    m_ar_len   = len_q;
    m_ar_id    = id_q;
    m_r_ready  = 1'b1;
    busy       = (state_q != StIdle);
    done       = done_q;
    issued_cnt = issued_q;
    beats_cnt  = beats_q;
    data_xor   = xor_q;
    errorCode  = err_q;
  end

endmodule

// File: tb/tb_axi_stride_read_initiator.sv
// Directed bench for axi_stride_read_initiator with an in-bench AXI read
// responder that returns data derived from address and beat number.
module tb_axi_stride_read_initiator;

  logic        clk;
  logic        resetN;
  logic        start;
  logic [15:0] cfg_base;
  logic [15:0] cfg_stride;
  logic [15:0] cfg_num_req;
  logic [7:0]  cfg_len;
  logic [7:0]  cfg_id;
  logic [3:0]  cfg_max_outstanding;
  logic [15:0] cfg_watchdog;
  logic        m_ar_valid;
  logic        m_ar_ready;
  logic [15:0] m_ar_addr;
  logic [7:0]  m_ar_len;
  logic [7:0]  m_ar_id;
  logic        m_r_valid;
  logic        m_r_ready;
  logic        m_r_last;
  logic [7:0]  m_r_data;
  logic [7:0]  m_r_id;
  logic        busy;
  logic        done;
  logic [15:0] issued_cnt;
  logic [15:0] beats_cnt;
  logic [7:0]  data_xor;
  logic [2:0]  errorCode;

  axi_stride_read_initiator dut (
    .clk                 (clk),
    .resetN              (resetN),
    .start               (start),
    .cfg_base            (cfg_base),
    .cfg_stride          (cfg_stride),
    .cfg_num_req         (cfg_num_req),
    .cfg_len             (cfg_len),
    .cfg_id              (cfg_id),
    .cfg_max_outstanding (cfg_max_outstanding),
    .cfg_watchdog        (cfg_watchdog),
    .m_ar_valid          (m_ar_valid),
    .m_ar_ready          (m_ar_ready),
    .m_ar_addr           (m_ar_addr),
    .m_ar_len            (m_ar_len),
    .m_ar_id             (m_ar_id),
    .m_r_valid           (m_r_valid),
    .m_r_ready           (m_r_ready),
    .m_r_last            (m_r_last),
    .m_r_data            (m_r_data),
    .m_r_id              (m_r_id),
    .busy                (busy),
    .done                (done),
    .issued_cnt          (issued_cnt),
    .beats_cnt           (beats_cnt),
    .data_xor            (data_xor),
    .errorCode           (errorCode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder model state.
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
  } burst_t;

  burst_t      bq[$];
  logic [15:0] ar_log[$];
  int          done_count = 0;
  int          beat = 0;
  logic        r_enable = 1'b1;
  logic        bad_id_once = 1'b0;
  int          early_last_at = -1;
  logic [7:0]  resp_id = 8'd0;

  function automatic logic [7:0] resp_data(input logic [15:0] a, input int b);
    return a[7:0] ^ a[15:8] ^ 8'(b * 37 + 1);
  endfunction

  // Handshakes are judged at negedge (inputs stable), responses change at posedge+1.
  initial begin : responder
    logic ar_fire, r_fire, rst_seen, r_was_last;
    m_ar_ready = 1'b1;
    m_r_valid  = 1'b0;
    m_r_last   = 1'b0;
    m_r_data   = 8'd0;
    m_r_id     = 8'd0;
    forever begin
      @(negedge clk);
      ar_fire    = m_ar_valid && m_ar_ready;
      r_fire     = m_r_valid && m_r_ready;
      r_was_last = m_r_last;
      rst_seen   = !resetN;
      if (ar_fire) begin
        bq.push_back('{addr: m_ar_addr, len: m_ar_len});
        ar_log.push_back(m_ar_addr);
      end
      if (done) done_count++;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        bq.delete();
        beat = 0;
      end else if (r_fire) begin
        if (bad_id_once) bad_id_once = 1'b0;
        if (r_was_last) begin
          if (bq.size() > 0) void'(bq.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
      if (!rst_seen && r_enable && bq.size() > 0) begin
        m_r_valid = 1'b1;
        m_r_data  = resp_data(bq[0].addr, beat);
        m_r_id    = bad_id_once ? 8'd6 : resp_id;
        m_r_last  = (beat == int'(bq[0].len)) || (beat == early_last_at);
      end else begin
        m_r_valid = 1'b0;
        m_r_last  = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] base;
    logic [15:0] stride;
    logic [15:0] num;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [3:0]  maxo;
    logic [15:0] wd;
    logic [15:0] exp_addr [5];
    logic [15:0] exp_beats;
  } vec_t;

  vec_t vecs [4];

  task automatic do_reset();
    @(posedge clk);
    #1 resetN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;
  endtask

  task automatic start_run(input logic [15:0] base, input logic [15:0] stride,
                           input logic [15:0] num, input logic [7:0] len,
                           input logic [7:0] id, input logic [3:0] maxo,
                           input logic [15:0] wd);
    @(posedge clk);
    #1;
    cfg_base            = base;
    cfg_stride          = stride;
    cfg_num_req         = num;
    cfg_len             = len;
    cfg_id              = id;
    cfg_max_outstanding = maxo;
    cfg_watchdog        = wd;
    resp_id             = id;
    ar_log.delete();
    done_count = 0;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_row(input int r);
    logic       ok;
    logic [7:0] exp_xor;
    exp_xor = 8'd0;
    for (int k = 0; k < int'(vecs[r].num); k++)
      for (int b = 0; b <= int'(vecs[r].len); b++)
        exp_xor ^= resp_data(vecs[r].exp_addr[k], b);
    start_run(vecs[r].base, vecs[r].stride, vecs[r].num, vecs[r].len, vecs[r].id,
              vecs[r].maxo, vecs[r].wd);
    wait_done(500, ok);
    check($sformatf("row%0d_done_seen", r), 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check($sformatf("row%0d_done_pulses", r), 32'(done_count), 32'd1);
    check($sformatf("row%0d_issued", r), 32'(issued_cnt), 32'(vecs[r].num));
    check($sformatf("row%0d_beats", r), 32'(beats_cnt), 32'(vecs[r].exp_beats));
    check($sformatf("row%0d_err", r), 32'(errorCode), 32'd0);
    check($sformatf("row%0d_xor", r), 32'(data_xor), 32'(exp_xor));
    check($sformatf("row%0d_busy", r), 32'(busy), 32'd0);
    check($sformatf("row%0d_ar_count", r), 32'(ar_log.size()), 32'(vecs[r].num));
    for (int k = 0; k < int'(vecs[r].num) && k < ar_log.size(); k++)
      check($sformatf("row%0d_addr%0d", r, k), 32'(ar_log[k]), 32'(vecs[r].exp_addr[k]));
  endtask

  initial begin : global_timeout
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin : main
    logic ok;
    vecs[0] = '{base: 16'h0eef, stride: 16'd3, num: 16'd4, len: 8'd0, id: 8'd5, maxo: 4'd4,
                wd: 16'd0, exp_addr: '{16'h0eef, 16'h0ef2, 16'h0ef5, 16'h0ef8, 16'h0000},
                exp_beats: 16'd4};
    vecs[1] = '{base: 16'hfffe, stride: 16'd3, num: 16'd3, len: 8'd3, id: 8'h21, maxo: 4'd8,
                wd: 16'd0, exp_addr: '{16'hfffe, 16'h0001, 16'h0004, 16'h0000, 16'h0000},
                exp_beats: 16'd12};
    vecs[2] = '{base: 16'h1000, stride: 16'h0100, num: 16'd5, len: 8'd1, id: 8'd7, maxo: 4'd0,
                wd: 16'd20, exp_addr: '{16'h1000, 16'h1100, 16'h1200, 16'h1300, 16'h1400},
                exp_beats: 16'd10};
    vecs[3] = '{base: 16'h0040, stride: 16'd1, num: 16'd0, len: 8'd0, id: 8'd1, maxo: 4'd1,
                wd: 16'd0, exp_addr: '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0},
                exp_beats: 16'd0};

    resetN = 1'b0;
    start = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_num_req = '0; cfg_len = '0; cfg_id = '0;
    cfg_max_outstanding = '0; cfg_watchdog = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ar_valid", 32'(m_ar_valid), 32'd0);
    check("rst_r_ready", 32'(m_r_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_issued", 32'(issued_cnt), 32'd0);
    check("rst_err", 32'(errorCode), 32'd0);
    @(posedge clk);
    #1 resetN = 1'b1;

    for (int r = 0; r < 4; r++) run_row(r);

    // R stalled with limit 2: issue must stop at 2 until responses flow.
    r_enable = 1'b0;
    start_run(16'h0eef, 16'd3, 16'd4, 8'd0, 8'd5, 4'd2, 16'd0);
    repeat (40) @(negedge clk);
    check("bp_issued_held", 32'(issued_cnt), 32'd2);
    check("bp_ar_count_held", 32'(ar_log.size()), 32'd2);
    @(posedge clk);
    #1 r_enable = 1'b1;
    wait_done(300, ok);
    check("bp_done_seen", 32'(ok), 32'd1);
    check("bp_issued_final", 32'(issued_cnt), 32'd4);
    check("bp_beats_final", 32'(beats_cnt), 32'd4);
    check("bp_err", 32'(errorCode), 32'd0);

    // Watchdog timeout with responses withheld.
    do_reset();
    r_enable = 1'b0;
    start_run(16'h0200, 16'd4, 16'd2, 8'd0, 8'd5, 4'd4, 16'd50);
    wait_done(200, ok);
    check("wd_done_seen", 32'(ok), 32'd1);
    check("wd_err", 32'(errorCode), 32'd5);
    check("wd_busy", 32'(busy), 32'd0);
    check("wd_ar_valid", 32'(m_ar_valid), 32'd0);
    check("wd_issued", 32'(issued_cnt), 32'd2);
    do_reset();
    r_enable = 1'b1;

    // Wrong R ID on the first beat: issue stops after the AR already in flight.
    bad_id_once = 1'b1;
    start_run(16'h0300, 16'd1, 16'd4, 8'd0, 8'd5, 4'd4, 16'd0);
    wait_done(200, ok);
    check("badid_done_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);
    check("badid_err", 32'(errorCode), 32'd1);
    check("badid_issued", 32'(issued_cnt), 32'd2);
    check("badid_ar_count", 32'(ar_log.size()), 32'd2);
    check("badid_busy", 32'(busy), 32'd0);

    // Early last on beat 1 of a 4-beat burst.
    early_last_at = 1;
    start_run(16'h0400, 16'd1, 16'd1, 8'd3, 8'd5, 4'd4, 16'd0);
    wait_done(200, ok);
    check("early_done_seen", 32'(ok), 32'd1);
    check("early_err", 32'(errorCode), 32'd2);
    check("early_beats", 32'(beats_cnt), 32'd2);
    early_last_at = -1;
    do_reset();

    // Reset mid-run with two bursts outstanding.
    r_enable = 1'b0;
    start_run(16'h0500, 16'd8, 16'd4, 8'd3, 8'd5, 4'd2, 16'd0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (issued_cnt == 16'd2) begin
        ok = 1'b1;
        break;
      end
    end
    check("mid_two_issued", 32'(ok), 32'd1);
    @(posedge clk);
    #1 resetN = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_ar_valid", 32'(m_ar_valid), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done), 32'd0);
    check("mid_issued", 32'(issued_cnt), 32'd0);
    check("mid_addr", 32'(m_ar_addr), 32'd0);
    check("mid_len", 32'(m_ar_len), 32'd0);
    check("mid_r_ready", 32'(m_r_ready), 32'd1);
    @(posedge clk);
    #1 begin
      resetN   = 1'b1;
      r_enable = 1'b1;
    end
    repeat (5) @(negedge clk);
    check("mid_no_done", 32'(done_count), 32'd0);
    run_row(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
